// File: rtl/gpio_slot_scheduler.sv
// gpio_slot_scheduler
// Shares one user GPIO pad group between NUM_REQ requester engines.
// Ownership is granted round-robin in bounded time slots. Every slot is
// followed by a tri-stated guard interval so two owners never drive the
// pads back to back.
module gpio_slot_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int IO_W      = 11,
   parameter int SLOT_W    = 16,
   parameter int GUARD_CYC = 2
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       en,
   input  logic [SLOT_W-1:0]          slot_len,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*IO_W-1:0]    req_out,
   input  logic [NUM_REQ*IO_W-1:0]    req_oeb,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy,
   output logic                       slot_done,
   output logic [IO_W-1:0]            io_out,
   output logic [IO_W-1:0]            io_oeb
);

   localparam int OW    = $clog2(NUM_REQ);
   // Counter serves both the slot (up to 2^SLOT_W-2) and the guard (up to 14).
   localparam int CNT_W = (SLOT_W > 4) ? SLOT_W : 4;
   localparam logic [CNT_W-1:0]   GUARD_LAST = (GUARD_CYC > 0) ? CNT_W'(GUARD_CYC - 1) : '0;
   localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GUARD  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [NUM_REQ-1:0]  grant_nx;
   logic [OW-1:0]       owner_nx;
   logic [OW-1:0]       winner;
   logic [OW-1:0]       cand;
   logic                found;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nx;
   logic [SLOT_W-1:0]   latched_len;
   logic [SLOT_W-1:0]   len_nx;
   logic                slot_done_nx;
   logic                slot_end;
   logic [IO_W-1:0]     sel_out;
   logic [IO_W-1:0]     sel_oeb;

   // Round-robin search: first set request after the last owner, wrapping.
   always_comb begin
      found  = 1'b0;
      winner = owner;
      cand   = owner;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = OW'((int'(owner) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // A slot ends on its last counted cycle, when the owner drops its
   // request, or when the scheduler is disabled.
   assign slot_end = (cnt == CNT_W'(latched_len - 1'b1)) || !req[owner] || !en;

   assign busy = (state != IDLE);

   // Next-state and next-value logic for the slot FSM.
   always_comb begin
      state_nx     = state;
      grant_nx     = grant;
      owner_nx     = owner;
      cnt_nx       = cnt;
      len_nx       = latched_len;
      slot_done_nx = 1'b0;
      case (state)
         IDLE: begin
            if (en && found) begin
               state_nx = ACTIVE;
               owner_nx = winner;
               grant_nx = ONE_HOT0 << winner;
               cnt_nx   = '0;
               len_nx   = (slot_len == '0) ? SLOT_W'(1) : slot_len;
            end
         end
         ACTIVE: begin
            cnt_nx = cnt + 1'b1;
            if (slot_end) begin
               grant_nx     = '0;
               slot_done_nx = 1'b1;
               cnt_nx       = '0;
               state_nx     = (GUARD_CYC == 0) ? IDLE : GUARD;
            end
         end
         GUARD: begin
            grant_nx = '0;
            if (cnt == GUARD_LAST) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            grant_nx = '0;
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   // State and control registers; owner resets to the last index so
   // requester 0 is searched first.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         grant       <= '0;
         owner       <= OW'(NUM_REQ - 1);
         slot_done   <= 1'b0;
         cnt         <= '0;
         latched_len <= SLOT_W'(1);
      end else begin
         state       <= state_nx;
         grant       <= grant_nx;
         owner       <= owner_nx;
         slot_done   <= slot_done_nx;
         cnt         <= cnt_nx;
         latched_len <= len_nx;
      end
   end

   // Pad mux: only the current owner drives, and only in ACTIVE; reset
   // tri-states the pads in the same cycle it is asserted.
   always_comb begin
      sel_out = '0;
      sel_oeb = '1;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (owner == OW'(k)) begin
            sel_out = req_out[k*IO_W +: IO_W];
            sel_oeb = req_oeb[k*IO_W +: IO_W];
         end
      end
      io_out = '0;
      io_oeb = '1;
      if ((state == ACTIVE) && !wb_rst_i) begin
         io_out = sel_out;
         io_oeb = sel_oeb;
      end
   end

endmodule

// File: tb/tb_gpio_slot_scheduler.sv
// Bench for gpio_slot_scheduler: a per-cycle vector table of inputs and
// expected outputs, expected values queued at drive time and compared
// mid-cycle.
module tb_gpio_slot_scheduler;

   localparam int NUM_REQ   = 4;
   localparam int IO_W      = 11;
   localparam int SLOT_W    = 16;
   localparam int GUARD_CYC = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    en;
   logic [SLOT_W-1:0]       slot_len;
   logic [NUM_REQ-1:0]      req;
   logic [NUM_REQ*IO_W-1:0] req_out;
   logic [NUM_REQ*IO_W-1:0] req_oeb;
   logic [NUM_REQ-1:0]      grant;
   logic [1:0]              owner;
   logic                    busy;
   logic                    slot_done;
   logic [IO_W-1:0]         io_out;
   logic [IO_W-1:0]         io_oeb;

   always #5 clk = ~clk;

   gpio_slot_scheduler #(
      .NUM_REQ  (NUM_REQ),
      .IO_W     (IO_W),
      .SLOT_W   (SLOT_W),
      .GUARD_CYC(GUARD_CYC)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .en       (en),
      .slot_len (slot_len),
      .req      (req),
      .req_out  (req_out),
      .req_oeb  (req_oeb),
      .grant    (grant),
      .owner    (owner),
      .busy     (busy),
      .slot_done(slot_done),
      .io_out   (io_out),
      .io_oeb   (io_oeb)
   );

   // One row = one clock cycle: inputs applied in that cycle and outputs
   // expected in that same cycle.
   typedef struct {
      logic        rst;
      logic        en;
      logic [3:0]  req;
      logic [15:0] len;
      logic [3:0]  g;
      logic [1:0]  own;
      logic        b;
      logic        d;
   } vec_t;

   typedef struct {
      int          row;
      logic [3:0]  g;
      logic [1:0]  own;
      logic        b;
      logic        d;
      logic [10:0] o;
      logic [10:0] oe;
   } exp_t;

   vec_t        vecs[$];
   exp_t        exp_q[$];
   logic [10:0] pad_out[4];
   logic [10:0] pad_oeb[4];
   int          n_pass = 0;
   int          n_chk  = 0;

   task automatic add(input int n, input int r, input int e, input int rq, input int l,
                      input int g, input int o, input int b, input int d);
      vec_t v;
      v.rst = r[0];
      v.en  = e[0];
      v.req = rq[3:0];
      v.len = l[15:0];
      v.g   = g[3:0];
      v.own = o[1:0];
      v.b   = b[0];
      v.d   = d[0];
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, expv);
   endtask

   initial begin
      exp_t ex;
      exp_t got;
      pad_out[0] = 11'h0A1; pad_out[1] = 11'h1B2; pad_out[2] = 11'h2C3; pad_out[3] = 11'h2A5;
      pad_oeb[0] = 11'h00F; pad_oeb[1] = 11'h0F0; pad_oeb[2] = 11'h700; pad_oeb[3] = 11'h000;
      req_out = {pad_out[3], pad_out[2], pad_out[1], pad_out[0]};
      req_oeb = {pad_oeb[3], pad_oeb[2], pad_oeb[1], pad_oeb[0]};
      rst = 1'b1; en = 1'b0; req = '0; slot_len = 16'd3;

      //   n rst en req len  grant own busy done
      // req=0101, len=3: 0 -> 2 -> 0 with 2 guard + 1 idle cycles between
      add(1, 0, 1, 5, 3,   0, 3, 0, 0);   // reset state, arbitration
      add(3, 0, 1, 5, 3,   1, 0, 1, 0);
      add(1, 0, 1, 5, 3,   0, 0, 1, 1);
      add(1, 0, 1, 5, 3,   0, 0, 1, 0);
      add(1, 0, 1, 5, 3,   0, 0, 0, 0);
      add(3, 0, 1, 5, 3,   4, 2, 1, 0);
      add(1, 0, 1, 5, 3,   0, 2, 1, 1);
      add(1, 0, 1, 5, 3,   0, 2, 1, 0);
      add(1, 0, 1, 5, 3,   0, 2, 0, 0);
      add(3, 0, 1, 5, 3,   1, 0, 1, 0);
      add(1, 0, 1, 5, 3,   0, 0, 1, 1);
      add(1, 0, 1, 5, 3,   0, 0, 1, 0);
      // slot_len=0 acts as 1, single requester 1: period 4
      add(1, 0, 1, 2, 0,   0, 0, 0, 0);
      add(1, 0, 1, 2, 0,   2, 1, 1, 0);
      add(1, 0, 1, 2, 0,   0, 1, 1, 1);
      add(1, 0, 1, 2, 0,   0, 1, 1, 0);
      add(1, 0, 1, 2, 0,   0, 1, 0, 0);
      add(1, 0, 1, 2, 0,   2, 1, 1, 0);
      add(1, 0, 1, 2, 0,   0, 1, 1, 1);
      add(1, 0, 1, 2, 0,   0, 1, 1, 0);
      add(1, 0, 0, 2, 0,   0, 1, 0, 0);   // disabled: stays idle
      // requester 3, len=10, drops req during its 4th slot cycle
      add(1, 0, 1, 8, 10,  0, 1, 0, 0);
      add(3, 0, 1, 8, 10,  8, 3, 1, 0);
      add(1, 0, 1, 0, 10,  8, 3, 1, 0);
      add(1, 0, 1, 0, 10,  0, 3, 1, 1);
      add(1, 0, 1, 0, 10,  0, 3, 1, 0);
      // req=1111, len=5, en dropped in 2nd slot cycle; no grant while en=0
      add(1, 0, 1, 15, 5,  0, 3, 0, 0);
      add(1, 0, 1, 15, 5,  1, 0, 1, 0);
      add(1, 0, 0, 15, 5,  1, 0, 1, 0);
      add(1, 0, 0, 15, 5,  0, 0, 1, 1);
      add(1, 0, 0, 15, 5,  0, 0, 1, 0);
      add(2, 0, 0, 15, 5,  0, 0, 0, 0);
      // slot_len 3 -> 7 mid-slot: this slot 3 cycles, next 7
      add(1, 0, 1, 4, 3,   0, 0, 0, 0);
      add(3, 0, 1, 4, 7,   4, 2, 1, 0);
      add(1, 0, 1, 4, 7,   0, 2, 1, 1);
      add(1, 0, 1, 4, 7,   0, 2, 1, 0);
      add(1, 0, 1, 4, 7,   0, 2, 0, 0);
      add(7, 0, 1, 4, 7,   4, 2, 1, 0);
      add(1, 0, 1, 4, 7,   0, 2, 1, 1);
      add(1, 0, 1, 4, 7,   0, 2, 1, 0);
      add(1, 0, 1, 4, 7,   0, 2, 0, 0);
      add(1, 0, 1, 4, 7,   4, 2, 1, 0);
      // reset pulsed mid-ACTIVE, then requester 3 wins first
      add(1, 1, 1, 8, 3,   4, 2, 1, 0);   // pads tri-stated this cycle
      add(1, 0, 1, 8, 3,   0, 3, 0, 0);
      add(3, 0, 1, 8, 3,   8, 3, 1, 0);
      add(1, 0, 1, 8, 3,   0, 3, 1, 1);

      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         rst      = vecs[i].rst;
         en       = vecs[i].en;
         req      = vecs[i].req;
         slot_len = vecs[i].len;
         ex.row = i;
         ex.g   = vecs[i].g;
         ex.own = vecs[i].own;
         ex.b   = vecs[i].b;
         ex.d   = vecs[i].d;
         ex.o   = ((vecs[i].g != 4'd0) && !vecs[i].rst) ? pad_out[vecs[i].own] : 11'h000;
         ex.oe  = ((vecs[i].g != 4'd0) && !vecs[i].rst) ? pad_oeb[vecs[i].own] : 11'h7FF;
         exp_q.push_back(ex);
         @(negedge clk);
         got = exp_q.pop_front();
         chk("grant",     got.row, 32'(grant),     32'(got.g));
         chk("owner",     got.row, 32'(owner),     32'(got.own));
         chk("busy",      got.row, 32'(busy),      32'(got.b));
         chk("slot_done", got.row, 32'(slot_done), 32'(got.d));
         chk("io_out",    got.row, 32'(io_out),    32'(got.o));
         chk("io_oeb",    got.row, 32'(io_oeb),    32'(got.oe));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
